// File: rtl/sort_stream_checker.sv
// Sink-side checker for the sorter output stream: framing, ordering and length per packet.
// Optional SORT_CHK_SUM_EN adds an input-vs-output packet sum (permutation) check.
module sort_stream_checker #(
   parameter int DATA_WIDTH = 8,
   parameter int ADR_WIDTH  = 3,
   parameter bit DESCENDING = 1'b0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  sop_i,
   input  logic                  eop_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  val_i,
`ifdef SORT_CHK_SUM_EN
   input  logic                  in_sop_i,
   input  logic                  in_eop_i,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   input  logic                  in_val_i,
   output logic                  err_sum_o,
`endif
   output logic                  done_o,
   output logic                  pkt_ok_o,
   output logic                  err_order_o,
   output logic                  err_frame_o,
   output logic                  err_len_o,
   output logic [ADR_WIDTH:0]    pkt_len_o,
   output logic [15:0]           pkt_cnt_o,
   output logic [15:0]           err_cnt_o,
   output logic                  err_sticky_o
);

   localparam int LEN_W = ADR_WIDTH + 1;
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(2**ADR_WIDTH + 1);
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

   typedef enum logic {IDLE, PKT} state_t;

   typedef struct packed {
      logic             order;
      logic             frame;
      logic             len_err;
      logic             sum_err;
      logic [LEN_W-1:0] len;
   } verdict_t;

   state_t                state_reg, state_next;
   logic [DATA_WIDTH-1:0] prev_reg, prev_next;
   logic [LEN_W-1:0]      len_reg, len_next, len_inc;
   logic                  acc_order_reg, acc_order_next;
   logic                  acc_len_reg, acc_len_next;
   logic                  ord_bad;

   verdict_t              new0, new1, emit, pend_reg, pend_next;
   logic                  new0_vld, new1_vld, emit_vld, emit_err;
   logic                  pend_vld_reg, pend_vld_next;

   logic                  done_reg, rpt_ok_reg, rpt_order_reg, rpt_frame_reg, rpt_len_reg;
   logic [LEN_W-1:0]      rpt_plen_reg;
   logic                  sticky_reg;

   logic                  sum_bad_single, sum_bad_close, sum_bad_cont, sum_bad_second;

   assign len_inc = (len_reg == LEN_MAX) ? LEN_MAX : len_reg + LEN_ONE;
   assign ord_bad = DESCENDING ? (data_i > prev_reg) : (data_i < prev_reg);

   always_comb begin
      state_next     = state_reg;
      prev_next      = prev_reg;
      len_next       = len_reg;
      acc_order_next = acc_order_reg;
      acc_len_next   = acc_len_reg;
      new0_vld       = 1'b0;
      new1_vld       = 1'b0;
      new0           = '0;
      new1           = '0;
      if (val_i) begin
         case (state_reg)
            IDLE: begin
               if (sop_i && eop_i) begin
                  new0_vld     = 1'b1;
                  new0.len     = LEN_ONE;
                  new0.sum_err = sum_bad_single;
               end else if (sop_i) begin
                  state_next     = PKT;
                  prev_next      = data_i;
                  len_next       = LEN_ONE;
                  acc_order_next = 1'b0;
                  acc_len_next   = 1'b0;
               end else begin
                  // orphan word: framing error with zero length
                  new0_vld   = 1'b1;
                  new0.frame = 1'b1;
               end
            end
            PKT: begin
               if (sop_i) begin
                  // close the open packet as misframed, then restart with this word
                  new0_vld       = 1'b1;
                  new0.frame     = 1'b1;
                  new0.order     = acc_order_reg;
                  new0.len_err   = acc_len_reg;
                  new0.len       = len_reg;
                  new0.sum_err   = sum_bad_close;
                  prev_next      = data_i;
                  len_next       = LEN_ONE;
                  acc_order_next = 1'b0;
                  acc_len_next   = 1'b0;
                  if (eop_i) begin
                     new1_vld     = 1'b1;
                     new1.len     = LEN_ONE;
                     new1.sum_err = sum_bad_second;
                     state_next   = IDLE;
                  end
               end else begin
                  len_next       = len_inc;
                  acc_order_next = acc_order_reg | ord_bad;
                  acc_len_next   = acc_len_reg | (len_inc == LEN_MAX);
                  prev_next      = data_i;
                  if (eop_i) begin
                     new0_vld     = 1'b1;
                     new0.order   = acc_order_next;
                     new0.len_err = acc_len_next;
                     new0.len     = len_inc;
                     new0.sum_err = sum_bad_cont;
                     state_next   = IDLE;
                  end
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // a pending verdict always goes out first; the state machine never creates a second one
   always_comb begin
      emit_vld      = 1'b0;
      emit          = '0;
      pend_vld_next = 1'b0;
      pend_next     = pend_reg;
      if (pend_vld_reg) begin
         emit_vld = 1'b1;
         emit     = pend_reg;
         if (new0_vld) begin
            pend_vld_next = 1'b1;
            pend_next     = new0;
         end
      end else if (new0_vld) begin
         emit_vld = 1'b1;
         emit     = new0;
         if (new1_vld) begin
            pend_vld_next = 1'b1;
            pend_next     = new1;
         end
      end
   end

   assign emit_err = emit.order | emit.frame | emit.len_err | emit.sum_err;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg     <= IDLE;
         prev_reg      <= '0;
         len_reg       <= '0;
         acc_order_reg <= 1'b0;
         acc_len_reg   <= 1'b0;
         pend_vld_reg  <= 1'b0;
         pend_reg      <= '0;
         done_reg      <= 1'b0;
         rpt_ok_reg    <= 1'b0;
         rpt_order_reg <= 1'b0;
         rpt_frame_reg <= 1'b0;
         rpt_len_reg   <= 1'b0;
         rpt_plen_reg  <= '0;
         sticky_reg    <= 1'b0;
      end else begin
         state_reg     <= state_next;
         prev_reg      <= prev_next;
         len_reg       <= len_next;
         acc_order_reg <= acc_order_next;
         acc_len_reg   <= acc_len_next;
         pend_vld_reg  <= pend_vld_next;
         pend_reg      <= pend_next;
         done_reg      <= emit_vld;
         if (emit_vld) begin
            rpt_ok_reg    <= ~emit_err;
            rpt_order_reg <= emit.order;
            rpt_frame_reg <= emit.frame;
            rpt_len_reg   <= emit.len_err;
            rpt_plen_reg  <= emit.len;
            if (emit_err) begin
               sticky_reg <= 1'b1;
            end
         end
      end
   end

   // saturating counters: [0] well-framed packets, [1] verdicts with any error
   logic [1:0]  cnt_inc;
   logic [15:0] cnt_val [2];

   assign cnt_inc = {emit_err, ~emit.frame} & {2{emit_vld}};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
         logic [15:0] cnt_reg;
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               cnt_reg <= '0;
            end else if (cnt_inc[gi] && (cnt_reg != 16'hFFFF)) begin
               cnt_reg <= cnt_reg + 16'd1;
            end
         end
         assign cnt_val[gi] = cnt_reg;
      end
   endgenerate

`ifdef SORT_CHK_SUM_EN
   localparam int SUM_W = DATA_WIDTH + ADR_WIDTH;

   logic [SUM_W-1:0] out_sum_reg, in_sum_reg, held_reg;
   logic [SUM_W-1:0] out_sum_cont, in_sum_total;
   logic             held_vld_reg, held_ovf_reg, rpt_sum_reg;
   logic             consume, held_vld_mid, held_ovf_mid;

   assign out_sum_cont   = out_sum_reg + SUM_W'(data_i);
   assign in_sum_total   = (in_sop_i ? '0 : in_sum_reg) + SUM_W'(in_data_i);
   assign sum_bad_single = ~held_vld_reg | held_ovf_reg | (held_reg != SUM_W'(data_i));
   assign sum_bad_close  = ~held_vld_reg | held_ovf_reg | (held_reg != out_sum_reg);
   assign sum_bad_cont   = ~held_vld_reg | held_ovf_reg | (held_reg != out_sum_cont);
   // the second verdict of a same-cycle pair finds the held sum already consumed
   assign sum_bad_second = 1'b1;

   // only packet verdicts (length >= 1) consume the held sum; orphans do not
   assign consume      = new0_vld & (new0.len != '0);
   assign held_vld_mid = held_vld_reg & ~consume;
   assign held_ovf_mid = held_ovf_reg & ~consume;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_sum_reg  <= '0;
         in_sum_reg   <= '0;
         held_reg     <= '0;
         held_vld_reg <= 1'b0;
         held_ovf_reg <= 1'b0;
         rpt_sum_reg  <= 1'b0;
      end else begin
         if (val_i) begin
            out_sum_reg <= sop_i ? SUM_W'(data_i) : out_sum_cont;
         end
         if (in_val_i) begin
            in_sum_reg <= in_sum_total;
         end
         if (in_val_i && in_eop_i) begin
            held_reg     <= in_sum_total;
            held_vld_reg <= 1'b1;
            held_ovf_reg <= held_ovf_mid | held_vld_mid;
         end else begin
            held_vld_reg <= held_vld_mid;
            held_ovf_reg <= held_ovf_mid;
         end
         if (emit_vld) begin
            rpt_sum_reg <= emit.sum_err;
         end
      end
   end

   assign err_sum_o = rpt_sum_reg;
`else
   assign sum_bad_single = 1'b0;
   assign sum_bad_close  = 1'b0;
   assign sum_bad_cont   = 1'b0;
   assign sum_bad_second = 1'b0;
`endif

   assign done_o       = done_reg;
   assign pkt_ok_o     = rpt_ok_reg;
   assign err_order_o  = rpt_order_reg;
   assign err_frame_o  = rpt_frame_reg;
   assign err_len_o    = rpt_len_reg;
   assign pkt_len_o    = rpt_plen_reg;
   assign pkt_cnt_o    = cnt_val[0];
   assign err_cnt_o    = cnt_val[1];
   assign err_sticky_o = sticky_reg;

endmodule

// File: tb/tb_sort_stream_checker.sv
// Randomized bench for sort_stream_checker: packet-level reference model plus literal scenarios.
module tb_sort_stream_checker;

   localparam int DW   = 8;
   localparam int AW   = 3;
   localparam int LMAX = (1 << AW) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sop = 1'b0, eop = 1'b0, val = 1'b0;
   logic [DW-1:0] data = '0;
   logic          done, ok, e_ord, e_frm, e_len, sticky;
   logic [AW:0]   plen;
   logic [15:0]   pcnt, ecnt;

   always #5 clk = ~clk;

   sort_stream_checker #(.DATA_WIDTH(DW), .ADR_WIDTH(AW), .DESCENDING(1'b0)) dut (
      .clk_i(clk), .rst_i(rst), .sop_i(sop), .eop_i(eop), .data_i(data), .val_i(val),
      .done_o(done), .pkt_ok_o(ok), .err_order_o(e_ord), .err_frame_o(e_frm),
      .err_len_o(e_len), .pkt_len_o(plen), .pkt_cnt_o(pcnt), .err_cnt_o(ecnt),
      .err_sticky_o(sticky)
   );

   int checks = 0;
   int errors = 0;

   function automatic void chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endfunction

   // ---------------- reference model: whole packets judged from their word lists
   typedef struct packed {
      logic       order;
      logic       frame;
      logic       lerr;
      logic [7:0] len;
   } vd_t;

   vd_t           vq[$];
   logic [DW-1:0] cur[$];
   bit            open = 1'b0;
   bit            exp_done = 1'b0, exp_rst = 1'b0, exp_st = 1'b0;
   vd_t           exp_v = '0;
   int            exp_pc = 0, exp_ec = 0;

   function automatic vd_t judge(input bit frame);
      vd_t v;
      v       = '0;
      v.frame = frame;
      for (int i = 1; i < cur.size(); i++) begin
         if (cur[i] < cur[i-1]) v.order = 1'b1;
      end
      v.len  = 8'((cur.size() > LMAX) ? LMAX : cur.size());
      v.lerr = (cur.size() >= LMAX);
      return v;
   endfunction

   always @(posedge clk) begin
      vd_t v;
      exp_rst = 1'b0;
      if (rst) begin
         vq.delete();
         cur.delete();
         open     = 1'b0;
         exp_done = 1'b0;
         exp_v    = '0;
         exp_pc   = 0;
         exp_ec   = 0;
         exp_st   = 1'b0;
         exp_rst  = 1'b1;
      end else begin
         if (val) begin
            if (sop) begin
               if (open) vq.push_back(judge(1'b1));
               cur.delete();
               cur.push_back(data);
               open = 1'b1;
               if (eop) begin
                  vq.push_back(judge(1'b0));
                  open = 1'b0;
               end
            end else if (open) begin
               cur.push_back(data);
               if (eop) begin
                  vq.push_back(judge(1'b0));
                  open = 1'b0;
               end
            end else begin
               v       = '0;
               v.frame = 1'b1;
               vq.push_back(v);
            end
         end
         if (vq.size() > 0) begin
            exp_v    = vq.pop_front();
            exp_done = 1'b1;
            if (!exp_v.frame && exp_pc < 16'hFFFF) exp_pc++;
            if (exp_v.order || exp_v.frame || exp_v.lerr) begin
               if (exp_ec < 16'hFFFF) exp_ec++;
               exp_st = 1'b1;
            end
         end else begin
            exp_done = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      chk("m.done", done, exp_done);
      chk("m.pkt_cnt", pcnt, exp_pc);
      chk("m.err_cnt", ecnt, exp_ec);
      chk("m.sticky", sticky, exp_st);
      if (exp_done || exp_rst) begin
         chk("m.ok", ok, exp_done && !(exp_v.order || exp_v.frame || exp_v.lerr));
         chk("m.order", e_ord, exp_v.order);
         chk("m.frame", e_frm, exp_v.frame);
         chk("m.lenerr", e_len, exp_v.lerr);
         chk("m.len", plen, exp_v.len);
      end
   end

   // ---------------- verdict capture for literal scenario checks
   typedef struct packed {
      logic        ok;
      logic        order;
      logic        frame;
      logic        lerr;
      logic [7:0]  len;
      logic [15:0] pc;
      logic [15:0] ec;
   } cap_t;

   cap_t cap[$];

   always @(negedge clk) begin
      if (done) cap.push_back({ok, e_ord, e_frm, e_len, 8'(plen), pcnt, ecnt});
   end

   task automatic word(input bit s, input bit e, input logic [DW-1:0] d);
      @(posedge clk);
      #1;
      val = 1'b1; sop = s; eop = e; data = d;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         val = 1'b0; sop = 1'b0; eop = 1'b0;
      end
   endtask

   task automatic chk_cap(input string nm, input int idx, input bit x_ok, input bit x_ord,
                          input bit x_frm, input bit x_len, input int x_plen,
                          input int x_pc, input int x_ec);
      if (cap.size() <= idx) begin
         checks++;
         errors++;
         $display("FAIL %s verdicts actual=%0d required=%0d", nm, cap.size(), idx + 1);
      end else begin
         chk({nm, ".ok"}, cap[idx].ok, x_ok);
         chk({nm, ".order"}, cap[idx].order, x_ord);
         chk({nm, ".frame"}, cap[idx].frame, x_frm);
         chk({nm, ".lenerr"}, cap[idx].lerr, x_len);
         chk({nm, ".len"}, cap[idx].len, x_plen);
         chk({nm, ".pkt_cnt"}, cap[idx].pc, x_pc);
         chk({nm, ".err_cnt"}, cap[idx].ec, x_ec);
      end
   endtask

   logic [DW-1:0] sorted_w [8] = '{8'h05, 8'h12, 8'h56, 8'hAA, 8'hAD, 8'hBC, 8'hC8, 8'hFA};
   logic [DW-1:0] last = '0;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst.done", done, 0);
      chk("rst.ok", ok, 0);
      chk("rst.len", plen, 0);
      chk("rst.pkt_cnt", pcnt, 0);
      chk("rst.sticky", sticky, 0);
      rst = 1'b0;
      idle(2);

      // sorted 8-word packet, verdict one cycle after the eop word
      cap.delete();
      for (int i = 0; i < 8; i++) word(i == 0, i == 7, sorted_w[i]);
      idle(1);
      chk("sorted.latency", done, 1);
      idle(2);
      chk("sorted.n", cap.size(), 1);
      chk_cap("sorted", 0, 1, 0, 0, 0, 8, 1, 0);

      // single word then a descending pair
      cap.delete();
      word(1, 1, 8'hFF);
      word(1, 0, 8'hFF);
      word(0, 1, 8'hAA);
      idle(3);
      chk_cap("single", 0, 1, 0, 0, 0, 1, 2, 0);
      chk_cap("desc", 1, 0, 1, 0, 0, 2, 3, 1);
      chk("desc.sticky", sticky, 1);

      // orphan word
      cap.delete();
      word(0, 0, 8'h5F);
      idle(3);
      chk_cap("orphan", 0, 0, 0, 1, 0, 0, 3, 2);

      // sop inside an open packet
      cap.delete();
      word(1, 0, 8'h11);
      word(0, 0, 8'h22);
      word(1, 0, 8'h33);
      word(0, 1, 8'h44);
      idle(3);
      chk("reopen.n", cap.size(), 2);
      chk_cap("reopen.a", 0, 0, 0, 1, 0, 2, 3, 3);
      chk_cap("reopen.b", 1, 1, 0, 0, 0, 2, 4, 3);

      // 9 ascending words overflow the length limit
      cap.delete();
      for (int i = 0; i < 9; i++) word(i == 0, i == 8, 8'(16 * (i + 1)));
      idle(3);
      chk_cap("long", 0, 0, 0, 0, 1, 9, 5, 4);

      // sop+eop inside a packet then an orphan: three verdicts back to back
      cap.delete();
      word(1, 0, 8'h01);
      word(0, 0, 8'h02);
      word(1, 1, 8'h03);
      word(0, 0, 8'h04);
      idle(4);
      chk("burst.n", cap.size(), 3);
      chk_cap("burst.a", 0, 0, 0, 1, 0, 2, 5, 5);
      chk_cap("burst.b", 1, 1, 0, 0, 0, 1, 6, 5);
      chk_cap("burst.c", 2, 0, 0, 1, 0, 0, 6, 6);

      // reset mid-packet, coinciding with the eop word
      cap.delete();
      for (int i = 0; i < 4; i++) word(i == 0, 1'b0, 8'(i + 1));
      word(0, 1, 8'h05);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      idle(2);
      chk("rstpkt.n", cap.size(), 0);
      chk("rstpkt.pkt_cnt", pcnt, 0);
      chk("rstpkt.err_cnt", ecnt, 0);
      chk("rstpkt.sticky", sticky, 0);
      chk("rstpkt.frame", e_frm, 0);
      word(1, 0, 8'h10);
      word(0, 0, 8'h20);
      word(0, 1, 8'h30);
      idle(3);
      chk_cap("after_rst", 0, 1, 0, 0, 0, 3, 1, 0);

      // randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 299) == 0) begin
            @(posedge clk);
            #1;
            rst = 1'b1;
            val = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            rst = 1'b0;
            val = 1'b0;
         end else if ($urandom_range(0, 3) == 0) begin
            idle(1);
         end else begin
            if ($urandom_range(0, 7) == 0) last = 8'($urandom);
            else last = last + 8'($urandom_range(0, 23));
            word($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, last);
         end
      end
      idle(4);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sort_stream_checker.md
# sort_stream_checker

Sink-side checker for the sorter's output packet stream (`sop`/`eop`/`val`/`data`). It accepts each output packet word by word and verifies three things: framing, non-decreasing order (or non-increasing) and packet length. It reports a per-packet verdict plus running counters. It sits on the sorter output in benches and optional on-chip self-test, and is the consumer counterpart of the sequence generator that feeds the sorter input.

## Interface
- `DATA_WIDTH`, 8: word width.
- `ADR_WIDTH`, 3: log2 of the maximum packet length (max 2^ADR_WIDTH words).
- `DESCENDING`, 0: 0 requires non-decreasing order, 1 requires non-increasing order; equal neighbours are always legal.
- `clk_i` in 1: single clock; all logic is on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `sop_i` in 1: start of packet, qualified by `val_i`.
- `eop_i` in 1: end of packet, qualified by `val_i`.
- `data_i` in DATA_WIDTH: data word.
- `val_i` in 1: word valid. Gaps are allowed anywhere.
- `done_o` out 1: one-cycle pulse; a verdict is present on the outputs below.
- `pkt_ok_o` out 1: no error in the reported packet; valid with `done_o`.
- `err_order_o`, `err_frame_o`, `err_len_o` out 1 each: error cause; valid with `done_o`.
- `pkt_len_o` out ADR_WIDTH+1: words counted in the reported packet; saturates at 2^ADR_WIDTH+1.
- `pkt_cnt_o` out 16: well-framed packets seen; saturates at 0xFFFF.
- `err_cnt_o` out 16: verdicts with any error; saturates at 0xFFFF.
- `err_sticky_o` out 1: set by any error; cleared only by `rst_i`.

## Operation
- FSM states are `IDLE` and `PKT`. Words with `val_i`=0 are ignored in both states.
- In `IDLE`:
  - `val&sop&eop`: single-word packet; issue the verdict and stay in `IDLE`.
  - `val&sop&!eop`: store `prev=data`, set `len=1`, go to `PKT`.
  - `val&!sop`: orphan word. Issue a verdict with `err_frame_o`=1 and `pkt_len_o`=0. The word does not increment `pkt_cnt_o`.
- In `PKT`, on `val&!sop`:
  - Increment `len`.
  - Check `data >= prev` (`<=` if DESCENDING). On failure set the order flag.
  - Set `prev=data`.
  - If `eop`, issue the verdict and go to `IDLE`.
- In `PKT`, on `val&sop`: sop inside a packet. Close the current packet with `err_frame_o`=1 and its current length, then restart as if in `IDLE` with this word. If `eop` is also set, the new single-word packet's verdict follows in the next cycle. The first verdict is registered and the second is queued one cycle later. At most one verdict is pending.
- Length error: when `len` reaches 2^ADR_WIDTH+1, set the length flag and keep counting to saturation.
- Order and length flags accumulate per packet and clear at each packet start.
- `pkt_ok_o = !(order|frame|len|sum)`.

## Timing
- Verdict latency is one cycle: `done_o` rises on the cycle after the edge that sampled the eop/orphan word.
- Back-to-back packets (eop word followed directly by the next sop word) are handled at full rate, one word per cycle.
- Reset values are 0 for every output, `state=IDLE`, and all counters 0.
- Reset mid-packet discards the partial packet and issues no verdict.
- If reset is asserted in the same cycle as an eop word, the reset wins and no verdict is issued.
- The order comparison is unsigned over DATA_WIDTH bits.

## Configuration
- With `SORT_CHK_SUM_EN` defined:
  - Add ports `in_sop_i`, `in_eop_i`, `in_data_i`, `in_val_i`, which tap the sorter input.
  - Accumulate the input-packet sum modulo 2^(DATA_WIDTH+ADR_WIDTH). On input eop, load it into a one-deep holding register and set its valid flag.
  - On output verdict, compare the output-packet sum with the held sum and clear the valid flag. A mismatch, or a flag not set, asserts `err_sum_o`.
  - An input eop while the flag is still set overwrites the register and asserts `err_sum_o` on the next verdict. This is a permutation check.
- Without the macro: no `in_*` ports, no `err_sum_o`, and the sum term is 0.

## Test plan
- Sorted packet `05 12 56 AA AD BC C8 FA` (sop on `05`, eop on `FA`) → `done_o` one cycle after `FA`, `pkt_len_o`=8, `pkt_ok_o`=1, `pkt_cnt_o`=1, `err_cnt_o`=0. With the macro, the input order `FA AA 56 12 AD C8 BC 05` gives sum 0x442 and `err_sum_o`=0.
- Single word `FF` with sop=eop=1 → `pkt_len_o`=1, `pkt_ok_o`=1. Then `FF`,`AA` as a 2-word packet → `err_order_o`=1, `err_cnt_o`=1, `err_sticky_o`=1.
- Orphan `val` word `5F` in `IDLE` → `done_o` with `err_frame_o`=1, `pkt_len_o`=0, `pkt_cnt_o` unchanged.
- `sop` on word 3 of an open packet `11 22 33`, then `44`+eop → first verdict `err_frame_o`=1 with `pkt_len_o`=2; second verdict `pkt_len_o`=2 with `pkt_ok_o`=1.
- 9 ascending words with ADR_WIDTH=3 → `err_len_o`=1, `pkt_len_o`=9.
- `rst_i` asserted after 4 words of a packet → no `done_o`, all outputs 0. A following valid packet gives `pkt_cnt_o`=1.
